bp_be_issue_buffer: RTL and testbench
=====================================

Name: bp_be_issue_buffer

Overview:
- Circular instruction buffer between the FE command/fetch interface and the BE issue/dispatch stage.
- Captures fetched (pc, instr, branch metadata) triples and presents the oldest unissued one to the issue stage, where the hazard detector evaluates it.
- Entries are retained until commit, so the issue pointer can rewind to the oldest uncommitted instruction on replay.
- Flushes on pipeline clear.

Parameters:
- entries_p, 8, buffer depth; must be a power of 2, ≥ 2
- vaddr_width_p, 39, PC width
- instr_width_p, 32, instruction width
- branch_metadata_fwd_width_p, 40, opaque FE metadata width
- ptr_width_lp, $clog2(entries_p)+1, derived; pointer width including wrap bit

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- fe_v_i  in  1  fetch packet valid
- fe_pc_i  in  vaddr_width_p  fetch PC
- fe_instr_i  in  instr_width_p  fetched instruction
- fe_meta_i  in  branch_metadata_fwd_width_p  branch metadata
- fe_ready_o  out  1  buffer can accept (not full)
- issue_v_o  out  1  head-of-issue entry valid
- issue_pc_o  out  vaddr_width_p  issue entry PC
- issue_instr_o  out  instr_width_p  issue entry instruction
- issue_meta_o  out  branch_metadata_fwd_width_p  issue entry metadata
- dispatch_v_i  in  1  issue entry accepted by dispatch this cycle
- commit_v_i  in  1  oldest uncommitted entry retires
- roll_v_i  in  1  replay: rewind issue pointer to commit pointer
- clr_v_i  in  1  flush all uncommitted entries
- occupancy_o  out  ptr_width_lp  entries held (wptr − cptr)

Behaviour:
- State: three pointers (wptr, rptr, cptr), each ptr_width_lp wide with MSB as wrap bit; storage is a flop array indexed by the low bits.
- Invariant: cptr ≤ rptr ≤ wptr (modular); occupancy = wptr − cptr.
- Reset: all pointers 0. Outputs after reset: fe_ready_o=1, issue_v_o=0, occupancy_o=0. Payload outputs are don't-care while issue_v_o=0; reset does not clear the storage array.
- full = (occupancy == entries_p). fe_ready_o = ~full, combinational from registered pointers only; it does not depend on same-cycle commit.
- Enqueue: fe_v_i & fe_ready_o & ~clr_v_i → write entry[wptr], wptr+1.
  - fe_v_i while full is dropped (protocol violation; assert).
  - The written entry is visible on issue outputs the next cycle (1-cycle latency).
- issue_v_o = (rptr != wptr); payload outputs = entry[rptr], combinational read.
- Dispatch: dispatch_v_i & issue_v_o → rptr+1. dispatch_v_i while ~issue_v_o is ignored (assert).
- Commit: commit_v_i → cptr+1. Commit with cptr == rptr is illegal (assert); the freed slot is available to fe_ready_o the next cycle.
- Roll: rptr_n = cptr_n, where cptr_n includes a same-cycle commit. Roll overrides dispatch. A same-cycle enqueue still proceeds.
- Clear: wptr_n = rptr_n = cptr_n (cptr_n includes a same-cycle commit). Clear overrides roll, dispatch and enqueue.
- Priority: reset > clr > roll > dispatch. Commit is independent and always applied when not in reset.
- Wrap-around: pointer increment carries into the wrap bit. full/empty are distinguished by the wrap bit alone; no extra counter.
- Simultaneous enqueue + commit while full: enqueue refused (fe_ready_o=0 from registered state); occupancy stays at entries_p−1 for one cycle.
- Reset mid-operation discards all entries. No output may reflect pre-reset payload as valid.

Test Plan:
1. entries_p=4. After reset, push pc 0x100, 0x104, 0x108, 0x10C on consecutive cycles, no dispatch → issue_v_o=1 from cycle 2 with issue_pc_o=0x100; fe_ready_o=0 after the 4th push; occupancy_o=4. A 5th fe_v_i asserts an error and leaves the state unchanged.
2. Continuous push and dispatch+commit for 12 instructions, pc 0x200+4k → issue order matches push order across two pointer wraps; occupancy_o never exceeds 4; no drops.
3. Push 3 (pc 0x300, 0x304, 0x308), dispatch 3, commit 1, then roll_v_i → next cycle issue_pc_o=0x304; occupancy_o=2. Dispatch again replays 0x304 then 0x308.
4. Full buffer, same cycle: commit_v_i, roll_v_i, dispatch_v_i → cptr+1; rptr = new cptr, so dispatch is lost. Next cycle fe_ready_o=1 and occupancy_o=3.
5. Occupancy 3 with 1 committed-pending, clr_v_i together with fe_v_i (pc 0x400) and commit_v_i → next cycle issue_v_o=0, occupancy_o=0, pc 0x400 not stored. A later push of pc 0x500 issues as 0x500.
6. Reset asserted with occupancy_o=3 and issue_v_o=1 → next cycle issue_v_o=0, occupancy_o=0, fe_ready_o=1. Behaviour after reset is identical to scenario 1.

Source files
------------

// File: rtl/bp_be_issue_buffer_if.sv
// FE-to-issue handshake bundle for the BE issue buffer.
// master drives fetch/control, slave is the buffer itself.
interface bp_be_issue_buffer_if #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int branch_metadata_fwd_width_p = 40,
  parameter int ptr_width_p = 4
);
  logic fe_v_i;
  logic [vaddr_width_p-1:0] fe_pc_i;
  logic [instr_width_p-1:0] fe_instr_i;
  logic [branch_metadata_fwd_width_p-1:0] fe_meta_i;
  logic fe_ready_o;

  logic issue_v_o;
  logic [vaddr_width_p-1:0] issue_pc_o;
  logic [instr_width_p-1:0] issue_instr_o;
  logic [branch_metadata_fwd_width_p-1:0] issue_meta_o;

  logic dispatch_v_i;
  logic commit_v_i;
  logic roll_v_i;
  logic clr_v_i;
  logic [ptr_width_p-1:0] occupancy_o;

  modport master (
    output fe_v_i, fe_pc_i, fe_instr_i, fe_meta_i,
    input  fe_ready_o,
    input  issue_v_o, issue_pc_o, issue_instr_o,
    input  issue_meta_o,
    output dispatch_v_i, commit_v_i, roll_v_i,
    output clr_v_i,
    input  occupancy_o
  );

  modport slave (
    input  fe_v_i, fe_pc_i, fe_instr_i, fe_meta_i,
    output fe_ready_o,
    output issue_v_o, issue_pc_o, issue_instr_o,
    output issue_meta_o,
    input  dispatch_v_i, commit_v_i, roll_v_i,
    input  clr_v_i,
    output occupancy_o
  );
endinterface

// File: rtl/bp_be_issue_buffer.sv
// Circular issue buffer: write/read/commit pointers with wrap bit,
// entries kept until commit so the read pointer can rewind on replay.
module bp_be_issue_buffer #(
  parameter int entries_p = 8,
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int branch_metadata_fwd_width_p = 40,
  localparam int ptr_width_lp = $clog2(entries_p) + 1
) (
  input logic clk_i,
  input logic reset_i,
  bp_be_issue_buffer_if.slave bi
);

  localparam int idx_w_lp = ptr_width_lp - 1;

  typedef logic [ptr_width_lp-1:0] ptr_t;
  typedef logic [idx_w_lp-1:0] idx_t;

  typedef struct packed {
    logic [vaddr_width_p-1:0] pc;
    logic [instr_width_p-1:0] instr;
    logic [branch_metadata_fwd_width_p-1:0] meta;
  } entry_t;

  localparam ptr_t one_lp = ptr_t'(1);
  localparam ptr_t full_lp = ptr_t'(entries_p);

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t cptr_q, cptr_d;
  entry_t mem_q [entries_p];
  entry_t mem_d [entries_p];

  ptr_t occ;
  logic full;
  logic issue_v;
  logic enq;
  logic deq;
  idx_t w_idx;
  idx_t r_idx;

  // Wrap bit alone separates full from empty.
  assign occ = wptr_q - cptr_q;
  assign full = (occ == full_lp);
  assign issue_v = (rptr_q != wptr_q);
  assign w_idx = wptr_q[idx_w_lp-1:0];
  assign r_idx = rptr_q[idx_w_lp-1:0];

  assign enq = bi.fe_v_i & ~full & ~bi.clr_v_i;
  assign deq = bi.dispatch_v_i & issue_v;

  always_comb begin
    cptr_d = cptr_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    if (bi.commit_v_i) begin
      cptr_d = cptr_q + one_lp;
    end
    unique case (1'b1)
      bi.clr_v_i: begin
        rptr_d = cptr_d;
        wptr_d = cptr_d;
      end
      bi.roll_v_i: begin
        rptr_d = cptr_d;
        if (enq) wptr_d = wptr_q + one_lp;
      end
      default: begin
        if (deq) rptr_d = rptr_q + one_lp;
        if (enq) wptr_d = wptr_q + one_lp;
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (enq) begin
      mem_d[w_idx] = '{
        pc: bi.fe_pc_i,
        instr: bi.fe_instr_i,
        meta: bi.fe_meta_i
      };
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Payload storage is not reset; issue_v gates its validity.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign bi.fe_ready_o = ~full;
  assign bi.issue_v_o = issue_v;
  assign bi.issue_pc_o = mem_q[r_idx].pc;
  assign bi.issue_instr_o = mem_q[r_idx].instr;
  assign bi.issue_meta_o = mem_q[r_idx].meta;
  assign bi.occupancy_o = occ;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(bi.fe_v_i && full))
        else $error("issue_buffer: push while full");
      assert (!(bi.dispatch_v_i && !issue_v))
        else $error("issue_buffer: dispatch while empty");
      assert (!(bi.commit_v_i && (cptr_q == rptr_q)))
        else $error("issue_buffer: commit past issue");
    end
  end

endmodule

// File: tb/tb_bp_be_issue_buffer.sv
// Scoreboard bench for bp_be_issue_buffer (entries_p = 4).
// Directed scenarios; a negedge monitor checks every dispatched entry.
module tb_bp_be_issue_buffer;

  localparam int E = 4;
  localparam int VW = 39;
  localparam int IW = 32;
  localparam int MW = 40;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic reset_i = 1'b1;

  bp_be_issue_buffer_if #(
    .vaddr_width_p(VW),
    .instr_width_p(IW),
    .branch_metadata_fwd_width_p(MW),
    .ptr_width_p(PW)
  ) bi ();

  bp_be_issue_buffer #(
    .entries_p(E),
    .vaddr_width_p(VW),
    .instr_width_p(IW),
    .branch_metadata_fwd_width_p(MW)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .bi(bi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pend = 0;
  int max_occ = 0;
  logic [VW-1:0] exp_q [$];

  function automatic logic [IW-1:0] mk_instr(logic [VW-1:0] pc);
    return 32'h0013_0000 ^ pc[31:0];
  endfunction

  function automatic logic [MW-1:0] mk_meta(logic [VW-1:0] pc);
    return {1'b1, ~pc};
  endfunction

  task automatic check(string name, logic [127:0] act,
                       logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pop on every accepted dispatch.
  always @(negedge clk) begin
    logic [VW-1:0] e;
    if (!reset_i && !bi.clr_v_i && !bi.roll_v_i &&
        bi.dispatch_v_i && bi.issue_v_o) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("issue_pc", bi.issue_pc_o, e);
        check("issue_payload",
              {bi.issue_instr_o, bi.issue_meta_o},
              {mk_instr(e), mk_meta(e)});
      end
    end
    if (reset_i || bi.clr_v_i) begin
      exp_q.delete();
    end else if (bi.fe_v_i && bi.fe_ready_o) begin
      exp_q.push_back(bi.fe_pc_i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(logic fe, logic [VW-1:0] pc, logic disp,
                       logic com, logic roll, logic clr);
    logic iv;
    bi.fe_v_i = fe;
    bi.fe_pc_i = pc;
    bi.fe_instr_i = mk_instr(pc);
    bi.fe_meta_i = mk_meta(pc);
    bi.dispatch_v_i = disp;
    bi.commit_v_i = com;
    bi.roll_v_i = roll;
    bi.clr_v_i = clr;
    iv = bi.issue_v_o;
    step();
    if (clr || roll) pend = 0;
    else pend = pend + int'(disp && iv) - int'(com);
    if (int'(bi.occupancy_o) > max_occ) max_occ = int'(bi.occupancy_o);
    bi.fe_v_i = 1'b0;
    bi.dispatch_v_i = 1'b0;
    bi.commit_v_i = 1'b0;
    bi.roll_v_i = 1'b0;
    bi.clr_v_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    pend = 0;
  endtask

  task automatic drain(string name);
    int n;
    for (n = 0; n < 64; n++) begin
      if (!bi.issue_v_o && pend == 0) break;
      cycle(1'b0, '0, bi.issue_v_o, pend > 0, 1'b0, 1'b0);
    end
    if (n == 64) check({name, "_drain_timeout"}, 1, 0);
  endtask

  task automatic s1_fill();
    check("rst_ready", bi.fe_ready_o, 1);
    check("rst_issue_v", bi.issue_v_o, 0);
    check("rst_occ", bi.occupancy_o, 0);
    cycle(1'b1, 39'h100, 0, 0, 0, 0);
    check("s1_issue_v", bi.issue_v_o, 1);
    check("s1_pc_first", bi.issue_pc_o, 39'h100);
    check("s1_occ1", bi.occupancy_o, 1);
    cycle(1'b1, 39'h104, 0, 0, 0, 0);
    cycle(1'b1, 39'h108, 0, 0, 0, 0);
    check("s1_ready_3", bi.fe_ready_o, 1);
    cycle(1'b1, 39'h10C, 0, 0, 0, 0);
    check("s1_ready_full", bi.fe_ready_o, 0);
    check("s1_occ_full", bi.occupancy_o, 4);
    check("s1_pc_head", bi.issue_pc_o, 39'h100);
    cycle(1'b0, '0, 0, 0, 0, 0);
    check("s1_hold_occ", bi.occupancy_o, 4);
  endtask

  initial begin
    bi.fe_v_i = 1'b0;
    bi.fe_pc_i = '0;
    bi.fe_instr_i = '0;
    bi.fe_meta_i = '0;
    bi.dispatch_v_i = 1'b0;
    bi.commit_v_i = 1'b0;
    bi.roll_v_i = 1'b0;
    bi.clr_v_i = 1'b0;
    step();
    do_reset();

    // Scenario 1 and 4: fill, dispatch one, commit+roll+dispatch.
    s1_fill();
    cycle(1'b0, '0, 1, 0, 0, 0);
    check("s4_pc_pre", bi.issue_pc_o, 39'h104);
    cycle(1'b0, '0, 1, 1, 1, 0);
    check("s4_ready", bi.fe_ready_o, 1);
    check("s4_occ", bi.occupancy_o, 3);
    check("s4_pc_after", bi.issue_pc_o, 39'h104);
    drain("s4");

    // Scenario 2: streaming across two pointer wraps.
    begin
      int k = 0;
      int n;
      max_occ = 0;
      for (n = 0; n < 200; n++) begin
        logic fe;
        if (k == 12 && !bi.issue_v_o && pend == 0) break;
        fe = (k < 12) && bi.fe_ready_o;
        cycle(fe, 39'h200 + 39'(4 * k), bi.issue_v_o,
              pend > 0, 0, 0);
        if (fe) k++;
      end
      check("s2_timeout", n == 200, 0);
      check("s2_pushed", k, 12);
      check("s2_occ_le4", max_occ > 4, 0);
      check("s2_empty_occ", bi.occupancy_o, 0);
    end

    // Scenario 3: replay after partial commit.
    cycle(1'b1, 39'h300, 0, 0, 0, 0);
    cycle(1'b1, 39'h304, 0, 0, 0, 0);
    cycle(1'b1, 39'h308, 0, 0, 0, 0);
    cycle(1'b0, '0, 1, 0, 0, 0);
    cycle(1'b0, '0, 1, 0, 0, 0);
    cycle(1'b0, '0, 1, 0, 0, 0);
    check("s3_issue_v_done", bi.issue_v_o, 0);
    cycle(1'b0, '0, 0, 1, 0, 0);
    exp_q.push_back(39'h304);
    exp_q.push_back(39'h308);
    cycle(1'b0, '0, 0, 0, 1, 0);
    check("s3_roll_pc", bi.issue_pc_o, 39'h304);
    check("s3_roll_v", bi.issue_v_o, 1);
    check("s3_roll_occ", bi.occupancy_o, 2);
    cycle(1'b0, '0, 1, 0, 0, 0);
    cycle(1'b0, '0, 1, 0, 0, 0);
    drain("s3");

    // Scenario 5: clear with same-cycle push and commit.
    cycle(1'b1, 39'h3A0, 0, 0, 0, 0);
    cycle(1'b1, 39'h3A4, 0, 0, 0, 0);
    cycle(1'b1, 39'h3A8, 0, 0, 0, 0);
    cycle(1'b0, '0, 1, 0, 0, 0);
    check("s5_occ_pre", bi.occupancy_o, 3);
    cycle(1'b1, 39'h400, 0, 1, 0, 1);
    check("s5_issue_v", bi.issue_v_o, 0);
    check("s5_occ", bi.occupancy_o, 0);
    check("s5_ready", bi.fe_ready_o, 1);
    cycle(1'b1, 39'h500, 0, 0, 0, 0);
    check("s5_pc_500", bi.issue_pc_o, 39'h500);
    check("s5_occ1", bi.occupancy_o, 1);
    drain("s5");

    // Scenario 6: reset mid-operation.
    cycle(1'b1, 39'h600, 0, 0, 0, 0);
    cycle(1'b1, 39'h604, 0, 0, 0, 0);
    cycle(1'b1, 39'h608, 0, 0, 0, 0);
    check("s6_occ_pre", bi.occupancy_o, 3);
    check("s6_v_pre", bi.issue_v_o, 1);
    do_reset();
    s1_fill();
    drain("s6");

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1, "timeout");
  end

endmodule
